vertex_accumulator: RTL and testbench

- Gather-phase read-modify-write engine for edge-centric processing. Consumes a stream of (destination vertex, update value) pairs from the scatter/shuffle stage and accumulates each value into a vertex-value store.
- The store is an internal simple dual-port BRAM with registered 1-cycle read.
- Also provides a store-clear sweep and a sequential readout stream for the apply/writeback stage.

---
 rtl/vertex_pkg.sv | 11 +
 rtl/vertex_accumulator_bram.sv | 20 ++
 rtl/vertex_accumulator.sv | 95 +++++++++
 tb/tb_vertex_accumulator.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vertex_pkg.sv
// vertex_pkg: shared types and defaults for the vertex accumulator.
// Contents: state encoding, default widths, update-beat struct.
package vertex_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 10;
    typedef enum logic [1:0] {IDLE, FLUSH, CLEAR, READOUT} state_t;
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } upd_beat_t;
endpackage

// File: rtl/vertex_accumulator_bram.sv
// vertex_accumulator_bram: simple dual-port store, registered 1-cycle read.
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out (registered).
// A same-address read and write in one cycle returns the pre-write value.
module vertex_accumulator_bram #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/vertex_accumulator.sv
// vertex_accumulator: gather-phase read-modify-write accumulator with clear sweep and readout stream.
// Ports: clk, rst (sync, active-high); clear_start/readout_start command pulses, busy;
//        upd_valid/upd_ready/upd_addr/upd_data update stream;
//        out_valid/out_addr/out_data/out_last readout stream (no backpressure).
module vertex_accumulator
    import vertex_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_start,
    input  logic              readout_start,
    output logic              busy,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

    state_t state, next, pend;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W-1:0] s1_addr, last_addr, raddr, waddr;
    logic [DATA_W-1:0] s1_data, last_data, rdata, base, sum, wdata;
    logic s1_valid, last_valid, accept, we, done;

    assign accept = upd_valid && upd_ready;
    assign done   = cnt == LAST;
    assign busy   = state != IDLE;

    always_comb begin
        next = state;
        case (state)
            IDLE:          next = (clear_start || readout_start) ? FLUSH : IDLE;
            FLUSH:         next = pend;
            CLEAR, READOUT: next = done ? IDLE : state;
            default:       next = IDLE;
        endcase
    end

    // Back-to-back updates to one address read the BRAM before the previous
    // write lands, so the previous write is taken from the last-write register.
    assign base  = (last_valid && last_addr == s1_addr) ? last_data : rdata;
    assign sum   = base + s1_data;
    assign raddr = (state == READOUT) ? cnt[ADDR_W-1:0] : upd_addr;
    // FLUSH guarantees S1 is empty whenever the clear writer owns the port.
    assign we    = !rst && (state == CLEAR || s1_valid);
    assign waddr = (state == CLEAR) ? cnt[ADDR_W-1:0] : s1_addr;
    assign wdata = (state == CLEAR) ? '0 : sum;
    assign out_data = out_valid ? rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend       <= IDLE;
            upd_ready  <= 1'b1;
            cnt        <= '0;
            s1_valid   <= 1'b0;
            last_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_addr   <= '0;
        end else begin
            state      <= next;
            upd_ready  <= next == IDLE;
            if (state == IDLE) pend <= clear_start ? CLEAR : READOUT;
            cnt        <= (busy && state != FLUSH) ? cnt + 1'b1 : '0;
            s1_valid   <= accept;
            last_valid <= s1_valid && next != CLEAR;
            out_valid  <= state == READOUT;
            out_last   <= state == READOUT && done;
            out_addr   <= cnt[ADDR_W-1:0];
        end
        s1_addr   <= upd_addr;
        s1_data   <= upd_data;
        last_addr <= s1_addr;
        last_data <= sum;
    end

    vertex_accumulator_bram #(.DW(DATA_W), .AW(ADDR_W)) u_bram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_vertex_accumulator.sv
// tb_vertex_accumulator: randomized self-checking bench against an array model of the store.
module tb_vertex_accumulator;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst, clear_start, readout_start, busy, upd_valid, upd_ready, out_valid, out_last;
    logic [AW-1:0] upd_addr, out_addr;
    logic [DW-1:0] upd_data, out_data;

    int checks = 0;
    int errors = 0;
    int model [DEPTH];
    logic [DW-1:0] snap [DEPTH];
    logic [DW-1:0] rd_data [DEPTH];
    logic [AW-1:0] rd_addr [DEPTH];
    logic rd_last [DEPTH];
    int rd_n, rd_extra;
    logic rdy_after_start;

    always #5 clk = ~clk;

    vertex_accumulator #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .clear_start   (clear_start),
        .readout_start (readout_start),
        .busy          (busy),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_addr      (upd_addr),
        .upd_data      (upd_data),
        .out_valid     (out_valid),
        .out_addr      (out_addr),
        .out_data      (out_data),
        .out_last      (out_last)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply(input int a, input int d);
        model[a] = (model[a] + d) % 256;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle busy stuck got %b want 0", busy);
        end
    endtask

    task automatic upd(input int a, input int d);
        upd_valid = 1'b1;
        upd_addr = AW'(a);
        upd_data = DW'(d);
        apply(a, d);
        step();
        upd_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        wait_idle();
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
    endtask

    // Streams the store out, capturing words; optional update alongside the
    // command and optional update in the cycle the final word appears.
    task automatic do_readout(input bit with_upd, input bit upd_at_last, input int a, input int d);
        rd_n = 0;
        rd_extra = 0;
        readout_start = 1'b1;
        if (with_upd) begin
            upd_valid = 1'b1;
            upd_addr = AW'(a);
            upd_data = DW'(d);
            apply(a, d);
        end
        for (int i = 0; i < DEPTH; i++) snap[i] = DW'(model[i]);
        step();
        rdy_after_start = upd_ready;
        readout_start = 1'b0;
        upd_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                if (rd_n < DEPTH) begin
                    rd_data[rd_n] = out_data;
                    rd_addr[rd_n] = out_addr;
                    rd_last[rd_n] = out_last;
                    rd_n++;
                end else rd_extra++;
                if (out_last && upd_at_last) begin
                    upd_valid = 1'b1;
                    upd_addr = AW'(a);
                    upd_data = DW'(d);
                    apply(a, d);
                end
            end
            step();
            upd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, upd_ready, out_valid, out_last, out_addr, out_data} !== {1'b0, 1'b1, 1'b0, 1'b0, AW'(0), DW'(0)}) begin
            errors++;
            $display("FAIL reset got busy %b rdy %b ov %b last %b addr %h data %h want 0 1 0 0 0 00",
                     busy, upd_ready, out_valid, out_last, out_addr, out_data);
        end
    endtask

    task automatic test_clear();
        int n = 0;
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
        checks++;
        if (n !== 1 + DEPTH) begin
            errors++;
            $display("FAIL clear_busy got %0d cycles want %0d", n, 1 + DEPTH);
        end
        do_readout(0, 0, 0, 0);
        checks++;
        if (rd_n !== DEPTH || rd_extra !== 0) begin errors++; $display("FAIL clear_count got %0d extra %0d want 16 0", rd_n, rd_extra); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if ({rd_addr[i], rd_last[i], rd_data[i]} !== {AW'(i), i == DEPTH-1, snap[i]}) begin
                errors++;
                $display("FAIL clear_word%0d got addr %0d last %b data %h want addr %0d last %b data %h",
                         i, rd_addr[i], rd_last[i], rd_data[i], i, i == DEPTH-1, snap[i]);
            end
        end
    endtask

    task automatic test_gapped();
        do_clear();
        upd(3, 5); step(); step();
        upd(7, 9); step();
        upd(3, 2); step(); step(); step();
        for (int k = 0; k < 8; k++) begin
            upd($urandom_range(DEPTH-1), $urandom_range(255));
            repeat ($urandom_range(3, 1)) step();
        end
        do_readout(0, 0, 0, 0);
        checks++;
        if (rd_n !== DEPTH || rd_extra !== 0) begin errors++; $display("FAIL gapped_count got %0d extra %0d want 16 0", rd_n, rd_extra); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if ({rd_addr[i], rd_last[i], rd_data[i]} !== {AW'(i), i == DEPTH-1, snap[i]}) begin
                errors++;
                $display("FAIL gapped_word%0d got addr %0d last %b data %h want addr %0d last %b data %h",
                         i, rd_addr[i], rd_last[i], rd_data[i], i, i == DEPTH-1, snap[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        for (int k = 0; k < 4; k++) begin
            upd_valid = 1'b1; upd_addr = 4'd5; upd_data = 8'd1; apply(5, 1); step();
        end
        upd_valid = 1'b0;
        do_readout(0, 0, 0, 0);
        checks++;
        if (rd_data[5] !== 8'h04) begin errors++; $display("FAIL b2b_same got %h want 04", rd_data[5]); end
        do_clear();
        upd_valid = 1'b1; upd_addr = 4'd5; upd_data = 8'd1; apply(5, 1); step();
        upd_addr = 4'd6; apply(6, 1); step();
        upd_addr = 4'd5; apply(5, 1); step();
        upd_valid = 1'b0;
        do_readout(0, 0, 0, 0);
        checks++;
        if ({rd_data[5], rd_data[6]} !== {8'h02, 8'h01}) begin
            errors++;
            $display("FAIL b2b_interleave got %h %h want 02 01", rd_data[5], rd_data[6]);
        end
        do_clear();
        for (int c = 0; c < 80; c++) begin
            upd_valid = ($urandom_range(3) != 0);
            upd_addr = AW'($urandom_range(3));
            upd_data = DW'($urandom_range(255));
            if (upd_valid) apply(int'(upd_addr), int'(upd_data));
            step();
        end
        upd_valid = 1'b0;
        do_readout(0, 0, 0, 0);
        checks++;
        if (rd_n !== DEPTH || rd_extra !== 0) begin errors++; $display("FAIL rand_count got %0d extra %0d want 16 0", rd_n, rd_extra); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if ({rd_addr[i], rd_last[i], rd_data[i]} !== {AW'(i), i == DEPTH-1, snap[i]}) begin
                errors++;
                $display("FAIL rand_word%0d got addr %0d last %b data %h want addr %0d last %b data %h",
                         i, rd_addr[i], rd_last[i], rd_data[i], i, i == DEPTH-1, snap[i]);
            end
        end
    endtask

    task automatic test_wrap();
        do_clear();
        upd(2, 8'hF0); step(); step();
        upd(2, 8'h20); step(); step();
        do_readout(0, 0, 0, 0);
        checks++;
        if (rd_data[2] !== 8'h10) begin errors++; $display("FAIL wrap got %h want 10", rd_data[2]); end
    endtask

    task automatic test_cmd_overlap();
        int ov = 0;
        int n = 0;
        do_clear();
        do_readout(1, 0, 3, 8'h11);
        checks++;
        if (rdy_after_start !== 1'b0) begin errors++; $display("FAIL overlap_ready got %b want 0", rdy_after_start); end
        checks++;
        if (rd_data[3] !== 8'h11) begin errors++; $display("FAIL overlap_word got %h want 11", rd_data[3]); end
        do_readout(0, 1, 9, 8'h33);
        checks++;
        if ({rd_last[DEPTH-1], rd_data[DEPTH-1], rd_data[9]} !== {1'b1, snap[DEPTH-1], snap[9]}) begin
            errors++;
            $display("FAIL last_idle_upd got last %b data %h a9 %h want 1 %h %h",
                     rd_last[DEPTH-1], rd_data[DEPTH-1], rd_data[9], snap[DEPTH-1], snap[9]);
        end
        do_readout(0, 0, 0, 0);
        checks++;
        if (rd_data[9] !== 8'h33) begin errors++; $display("FAIL last_idle_applied got %h want 33", rd_data[9]); end
        clear_start = 1'b1;
        readout_start = 1'b1;
        step();
        clear_start = 1'b0;
        readout_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) ov++;
            if (busy) n++;
            step();
        end
        checks++;
        if (ov !== 0 || n !== 1 + DEPTH) begin
            errors++;
            $display("FAIL both_cmds got out_valid %0d busy %0d want 0 %0d", ov, n, 1 + DEPTH);
        end
    endtask

    task automatic test_reset_abort();
        int ov = 0;
        int bz = 0;
        do_clear();
        for (int i = 0; i < DEPTH; i++) upd(i, 8'hAA);
        step();
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) ov++;
            if (busy) bz++;
            step();
        end
        checks++;
        if (ov !== 0 || bz !== 0) begin errors++; $display("FAIL abort_quiet got out_valid %0d busy %0d want 0 0", ov, bz); end
        do_readout(0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 5) begin
                checks++;
                if (rd_data[i] !== snap[i]) begin
                    errors++;
                    $display("FAIL abort_word%0d got %h want %h", i, rd_data[i], snap[i]);
                end
            end
        end
        checks++;
        if (rd_data[5] !== 8'h00 && rd_data[5] !== 8'hAA) begin errors++; $display("FAIL abort_edge got %h want 00 or AA", rd_data[5]); end
        do_clear();
        do_readout(0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (rd_data[i] !== 8'h00) begin errors++; $display("FAIL reclear_word%0d got %h want 00", i, rd_data[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_start = 1'b0;
        readout_start = 1'b0;
        upd_valid = 1'b0;
        upd_addr = '0;
        upd_data = '0;
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_clear();
        test_gapped();
        test_back_to_back();
        test_wrap();
        test_cmd_overlap();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
